// File: rtl/framer_pkg.sv
// Shared types and constants for the result framer.
package framer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHeader,
    StData,
    StCheck
  } state_e;

  localparam logic [3:0] DefaultSync = 4'hA;

endpackage

// File: rtl/result_framer.sv
// Serialises a latched mode code and NUM_WORDS result words into a byte frame:
// header {SYNC, 0, mode}, data bytes (word 0 first, MSB first), XOR checksum.
module result_framer
  import framer_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 2,
  parameter int unsigned WORD_W    = 32,
  parameter logic [3:0]  SYNC      = DefaultSync
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [2:0]                    mode,
  input  logic [NUM_WORDS*WORD_W-1:0]   words,
  input  logic                          out_ready,
  output logic [7:0]                    out_byte,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          dropped
);

  localparam int WordW        = int'(WORD_W);
  localparam int BytesPerWord = WordW / 8;
  localparam int NumBytes     = int'(NUM_WORDS) * BytesPerWord;
  localparam int IdxW         = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam int IdxSpan      = 2 ** IdxW;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBytes - 1);

  if (NUM_WORDS < 1 || NUM_WORDS > 8 || WORD_W < 8 || WORD_W > 64 || (WORD_W % 8) != 0)
  begin : g_bad_params
    $error("result_framer: illegal NUM_WORDS=%0d or WORD_W=%0d", NUM_WORDS, WORD_W);
  end

  state_e                        state_q;
  logic [2:0]                    mode_q;
  logic [NUM_WORDS*WORD_W-1:0]   words_q;
  logic [7:0]                    csum_q;
  logic [IdxW-1:0]               idx_q;

  logic [7:0] data_bytes [IdxSpan];
  logic [7:0] header_byte;

  assign header_byte = {SYNC, 1'b0, mode_q};

  // Flatten the latched words into transmit order; unused index slots read as zero.
  always_comb begin
    for (int b = 0; b < IdxSpan; b++) begin
      data_bytes[b] = 8'h00;
    end
    for (int b = 0; b < NumBytes; b++) begin
      data_bytes[b] = words_q[(b / BytesPerWord) * WordW
                              + (BytesPerWord - 1 - (b % BytesPerWord)) * 8 +: 8];
    end
  end

  // Output byte and handshake flags, all derived from registered state.
  always_comb begin
    out_byte = 8'h00;
    unique case (state_q)
      StHeader: out_byte = header_byte;
      StData:   out_byte = data_bytes[idx_q];
      StCheck:  out_byte = csum_q;
      default:  out_byte = 8'h00;
    endcase
    out_valid  = (state_q != StIdle);
    busy       = (state_q != StIdle);
    frame_done = (state_q == StCheck) && out_ready;
    // Start is only honoured in IDLE, so any start seen while busy is lost.
    dropped    = start && (state_q != StIdle);
  end

  // Frame sequencer: latches inputs on start and advances one byte per accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mode_q  <= '0;
      words_q <= '0;
      csum_q  <= '0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mode_q  <= mode;
            words_q <= words;
            csum_q  <= '0;
            idx_q   <= '0;
            state_q <= StHeader;
          end
        end
        StHeader: begin
          if (out_ready) begin
            csum_q  <= csum_q ^ out_byte;
            state_q <= StData;
          end
        end
        StData: begin
          if (out_ready) begin
            csum_q <= csum_q ^ out_byte;
            // Stop at the last byte instead of incrementing so the index never wraps.
            if (idx_q == LastIdx) begin
              state_q <= StCheck;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end
        end
        StCheck: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_result_framer.sv
// Scoreboard bench for result_framer: stimulus pushes expected bytes, monitors pop and compare.
module tb_result_framer;

  localparam int NW = 2;
  localparam int WW = 32;
  localparam int NB = NW * WW / 8;

  typedef struct {
    logic [7:0] b;
    bit         first;
    bit         last;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [2:0]       mode;
  logic [NW*WW-1:0] words;
  logic             out_ready;
  logic [7:0]       out_byte;
  logic             out_valid;
  logic             busy;
  logic             frame_done;
  logic             dropped;

  logic       s_start;
  logic [2:0] s_mode;
  logic [7:0] s_words;
  logic       s_ready;
  logic [7:0] s_byte;
  logic       s_valid;
  logic       s_busy;
  logic       s_done;
  logic       s_dropped;

  exp_t q1[$];
  exp_t q2[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   ready_mode = 0;
  int   phase = 0;
  int   drops_seen = 0;
  int   exp_drops = 0;
  int   done_seen = 0;
  int   exp_done = 0;
  int   s_done_seen = 0;
  int   s_exp_done = 0;
  int   first_cyc = 0;
  bit   hold = 0;
  logic [7:0] held = '0;

  result_framer #(
    .NUM_WORDS(NW),
    .WORD_W   (WW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .words     (words),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .busy      (busy),
    .frame_done(frame_done),
    .dropped   (dropped)
  );

  result_framer #(
    .NUM_WORDS(1),
    .WORD_W   (8)
  ) dut_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (s_start),
    .mode      (s_mode),
    .words     (s_words),
    .out_ready (s_ready),
    .out_byte  (s_byte),
    .out_valid (s_valid),
    .busy      (s_busy),
    .frame_done(s_done),
    .dropped   (s_dropped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: a frame is the header, the words split MSB-first, then the XOR of all.
  function automatic void model_frame(input logic [2:0] m, input logic [NW*WW-1:0] w);
    logic [7:0]       hdr;
    logic [7:0]       cs;
    logic [NW*WW-1:0] t;
    hdr = {4'hA, 1'b0, m};
    cs  = hdr;
    q1.push_back('{b: hdr, first: 1'b1, last: 1'b0});
    for (int k = 0; k < NW; k++) begin
      for (int j = 0; j < WW / 8; j++) begin
        t  = w >> (k * WW + WW - 8 * (j + 1));
        cs = cs ^ t[7:0];
        q1.push_back('{b: t[7:0], first: 1'b0, last: 1'b0});
      end
    end
    q1.push_back('{b: cs, first: 1'b0, last: 1'b1});
  endfunction

  // Known-good frame for mode 5, words 12345678 / CAFEBABE.
  function automatic void push_golden();
    logic [7:0] g [10];
    g = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h9D};
    for (int i = 0; i < 10; i++) begin
      q1.push_back('{b: g[i], first: (i == 0), last: (i == 9)});
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 300) begin
      step();
      t++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while ((q1.size() != 0 || busy) && t < 300) begin
      step();
      t++;
    end
    chk(nm, q1.size(), 0);
  endtask

  task automatic wait_q(input int n, input string nm);
    int t = 0;
    while (q1.size() != n && t < 300) begin
      step();
      t++;
    end
    chk(nm, q1.size(), n);
  endtask

  // Issue one start; inputs are scrambled right after so only the latched copy matters.
  task automatic send(input logic [2:0] m, input logic [NW*WW-1:0] w, input bit golden);
    wait_idle();
    start = 1'b1;
    mode  = m;
    words = w;
    if (golden) push_golden();
    else model_frame(m, w);
    exp_done++;
    step();
    start = 1'b0;
    mode  = 3'($urandom);
    words = {$urandom, $urandom};
  endtask

  task automatic pulse_busy_start();
    start = 1'b1;
    mode  = 3'($urandom);
    words = {$urandom, $urandom};
    exp_drops++;
    step();
    start = 1'b0;
  endtask

  // Ready pattern generator.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (phase == 0);
          phase = (phase + 1) % 3;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor for the main instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("busy_vs_valid", busy, out_valid);
      if (out_valid) begin
        if (hold) chk("hold_stable", out_byte, held);
        if (out_ready) begin
          if (q1.size() == 0) begin
            chk("unexpected_byte", q1.size(), 1);
          end else begin
            e = q1.pop_front();
            chk("byte", out_byte, e.b);
            chk("frame_done", frame_done, e.last);
            if (e.first) first_cyc = cyc;
            if (e.last && ready_mode == 0) chk("no_bubble", cyc - first_cyc, NB + 1);
          end
        end else begin
          chk("done_without_accept", frame_done, 0);
        end
      end else begin
        chk("idle_byte", out_byte, 0);
        chk("idle_done", frame_done, 0);
      end
      if (dropped) drops_seen++;
      if (frame_done) done_seen++;
      hold = out_valid && !out_ready;
      held = out_byte;
    end else begin
      hold = 1'b0;
    end
  end

  // Monitor for the single-byte-word instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("s_dropped", s_dropped, 0);
      if (s_valid && s_ready) begin
        if (q2.size() == 0) begin
          chk("s_unexpected_byte", q2.size(), 1);
        end else begin
          e = q2.pop_front();
          chk("s_byte", s_byte, e.b);
          chk("s_frame_done", s_done, e.last);
        end
      end else if (!s_valid) begin
        chk("s_idle_byte", s_byte, 0);
      end
      if (s_done) s_done_seen++;
    end
  end

  task automatic send_small(input logic [2:0] m, input logic [7:0] w, input bit golden);
    logic [7:0] hdr;
    int t = 0;
    while (s_busy && t < 50) begin
      step();
      t++;
    end
    chk("s_idle_timeout", s_busy, 0);
    hdr = {4'hA, 1'b0, m};
    if (golden) begin
      q2.push_back('{b: 8'hA0, first: 1'b1, last: 1'b0});
      q2.push_back('{b: 8'hFF, first: 1'b0, last: 1'b0});
      q2.push_back('{b: 8'h5F, first: 1'b0, last: 1'b1});
    end else begin
      q2.push_back('{b: hdr, first: 1'b1, last: 1'b0});
      q2.push_back('{b: w, first: 1'b0, last: 1'b0});
      q2.push_back('{b: hdr ^ w, first: 1'b0, last: 1'b1});
    end
    s_exp_done++;
    s_start = 1'b1;
    s_mode  = m;
    s_words = w;
    step();
    s_start = 1'b0;
    s_mode  = 3'($urandom);
    s_words = 8'($urandom);
    t = 0;
    while ((q2.size() != 0 || s_busy) && t < 50) begin
      step();
      t++;
    end
    chk("s_frame_drain", q2.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NW*WW-1:0] golden_w;
    golden_w = {32'hCAFEBABE, 32'h12345678};
    rst_n   = 1'b1;
    start   = 1'b0;
    mode    = '0;
    words   = '0;
    s_start = 1'b0;
    s_mode  = '0;
    s_words = '0;
    s_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", frame_done, 0);
    chk("reset_dropped", dropped, 0);
    chk("reset_byte", out_byte, 0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Golden frame, back-to-back bytes.
    ready_mode = 0;
    send(3'b101, golden_w, 1'b1);
    wait_done("golden_drain");

    // Same frame under 1,0,0 ready pattern.
    ready_mode = 1;
    phase = 0;
    send(3'b101, golden_w, 1'b1);
    wait_done("golden_ready_drain");

    // Starts during DATA and in the checksum-accept cycle are dropped.
    ready_mode = 0;
    send(3'($urandom), {$urandom, $urandom}, 1'b0);
    wait_q(5, "reach_data");
    pulse_busy_start();
    wait_q(1, "reach_check");
    pulse_busy_start();
    wait_done("drop_frame_drain");

    // Reset after the 4th byte abandons the frame.
    ready_mode = 2;
    send(3'($urandom), {$urandom, $urandom}, 1'b0);
    wait_q(NB + 2 - 4, "reach_fourth");
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", out_valid, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", frame_done, 0);
    chk("midreset_byte", out_byte, 0);
    q1.delete();
    exp_done--;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    ready_mode = 0;
    send(3'b101, golden_w, 1'b1);
    wait_done("post_reset_drain");

    // Randomised frames and ready patterns.
    for (int i = 0; i < 20; i++) begin
      ready_mode = $urandom_range(0, 2);
      send(3'($urandom), {$urandom, $urandom}, 1'b0);
      wait_done("random_drain");
    end

    // Minimal configuration: one 8-bit word.
    send_small(3'b000, 8'hFF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send_small(3'($urandom), 8'($urandom), 1'b0);
    end

    step();
    chk("dropped_count", drops_seen, exp_drops);
    chk("done_count", done_seen, exp_done);
    chk("s_done_count", s_done_seen, s_exp_done);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
